// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default field widths, opcode encodings and the
// reservation-station entry record used by the stations and their models.
package tomasulo_pkg;

  localparam int DEF_FUNC_W = 4;
  localparam int DEF_ROB_W  = 3;
  localparam int DEF_REG_W  = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_AGE_W  = 4;

  localparam logic [DEF_FUNC_W-1:0] OP_ADD = 4'b0000;
  localparam logic [DEF_FUNC_W-1:0] OP_SUB = 4'b0001;
  localparam logic [DEF_FUNC_W-1:0] OP_MUL = 4'b0010;
  localparam logic [DEF_FUNC_W-1:0] OP_DIV = 4'b0011;
  localparam logic [DEF_FUNC_W-1:0] OP_LD  = 4'b0100;
  localparam logic [DEF_FUNC_W-1:0] OP_ST  = 4'b0101;
  localparam logic [DEF_FUNC_W-1:0] OP_BEQ = 4'b0110;
  localparam logic [DEF_FUNC_W-1:0] OP_BNE = 4'b0111;

  typedef struct packed {
    logic                  busy;
    logic [DEF_FUNC_W-1:0] func;
    logic [DEF_ROB_W-1:0]  rob;
    logic [DEF_REG_W-1:0]  rd;
    logic                  rdy1;
    logic [DEF_DATA_W-1:0] v1;
    logic [DEF_ROB_W-1:0]  t1;
    logic                  rdy2;
    logic [DEF_DATA_W-1:0] v2;
    logic [DEF_ROB_W-1:0]  t2;
    logic [DEF_AGE_W-1:0]  age;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Combinational oldest-ready picker: among candidate entries, returns the
// index of the one with the smallest age (0 = oldest) and a found flag.
module rs_age_select #(
  parameter int DEPTH = 4,
  parameter int AGE_W = 2,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       cand_i,
  input  logic [DEPTH*AGE_W-1:0] ages_i,
  output logic [IDX_W-1:0]       sel_o,
  output logic                   found_o
);

  logic             found;
  logic [IDX_W-1:0] sel;
  logic [AGE_W-1:0] best;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    best  = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand_i[i] && (!found || ages_i[i*AGE_W +: AGE_W] < best)) begin
        found = 1'b1;
        sel   = IDX_W'(i);
        best  = ages_i[i*AGE_W +: AGE_W];
      end
    end
  end

  assign sel_o   = sel;
  assign found_o = found;

endmodule

// File: rtl/rs_station.sv
// Reservation station: captures renamed instructions, snoops the CDB for
// missing operands and dispatches the oldest fully-ready entry each cycle.
module rs_station #(
  parameter int DEPTH  = 4,
  parameter int FUNC_W = tomasulo_pkg::DEF_FUNC_W,
  parameter int ROB_W  = tomasulo_pkg::DEF_ROB_W,
  parameter int REG_W  = tomasulo_pkg::DEF_REG_W,
  parameter int DATA_W = tomasulo_pkg::DEF_DATA_W,
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [FUNC_W-1:0] alloc_func,
  input  logic [ROB_W-1:0]  alloc_rob,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic              alloc_rdy1,
  input  logic [DATA_W-1:0] alloc_v1,
  input  logic [ROB_W-1:0]  alloc_t1,
  input  logic              alloc_rdy2,
  input  logic [DATA_W-1:0] alloc_v2,
  input  logic [ROB_W-1:0]  alloc_t2,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [FUNC_W-1:0] iss_func,
  output logic [DATA_W-1:0] iss_v1,
  output logic [DATA_W-1:0] iss_v2,
  output logic [ROB_W-1:0]  iss_rob,
  output logic [REG_W-1:0]  iss_rd,
  output logic [CNT_W-1:0]  count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AGE_W = IDX_W;

  typedef struct packed {
    logic              busy;
    logic [FUNC_W-1:0] func;
    logic [ROB_W-1:0]  rob;
    logic [REG_W-1:0]  rd;
    logic              rdy1;
    logic [DATA_W-1:0] v1;
    logic [ROB_W-1:0]  t1;
    logic              rdy2;
    logic [DATA_W-1:0] v2;
    logic [ROB_W-1:0]  t2;
    logic [AGE_W-1:0]  age;
  } entry_t;

  entry_t entries_q [DEPTH];
  entry_t entries_d [DEPTH];
  entry_t new_e;

  logic [CNT_W-1:0]       count_q, count_d;
  logic                   alloc_ready_q;
  logic [DEPTH-1:0]       cand;
  logic [DEPTH*AGE_W-1:0] ages;
  logic [IDX_W-1:0]       sel_idx, free_idx;
  logic                   sel_found, do_alloc, do_iss;

  always_comb begin
    cand = '0;
    ages = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = entries_q[i].busy & entries_q[i].rdy1 & entries_q[i].rdy2;
      ages[i*AGE_W +: AGE_W] = entries_q[i].age;
    end
  end

  rs_age_select #(.DEPTH(DEPTH), .AGE_W(AGE_W)) u_age_select (
    .cand_i  (cand),
    .ages_i  (ages),
    .sel_o   (sel_idx),
    .found_o (sel_found)
  );

  // Flush suppresses dispatch in the same cycle it clears the station.
  assign iss_valid   = sel_found & ~flush;
  assign iss_func    = iss_valid ? entries_q[sel_idx].func : '0;
  assign iss_v1      = iss_valid ? entries_q[sel_idx].v1   : '0;
  assign iss_v2      = iss_valid ? entries_q[sel_idx].v2   : '0;
  assign iss_rob     = iss_valid ? entries_q[sel_idx].rob  : '0;
  assign iss_rd      = iss_valid ? entries_q[sel_idx].rd   : '0;
  assign count       = count_q;
  assign alloc_ready = alloc_ready_q;

  assign do_iss   = iss_valid & iss_ready;
  assign do_alloc = alloc_valid & alloc_ready_q;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!entries_q[i].busy) free_idx = IDX_W'(i);
    end
  end

  // The incoming instruction may catch its producer's broadcast on the way in.
  always_comb begin
    new_e      = '0;
    new_e.busy = 1'b1;
    new_e.func = alloc_func;
    new_e.rob  = alloc_rob;
    new_e.rd   = alloc_rd;
    new_e.t1   = alloc_t1;
    new_e.t2   = alloc_t2;
    new_e.rdy1 = alloc_rdy1 | (cdb_valid & (alloc_t1 == cdb_tag));
    new_e.rdy2 = alloc_rdy2 | (cdb_valid & (alloc_t2 == cdb_tag));
    new_e.v1   = alloc_rdy1 ? alloc_v1 : cdb_data;
    new_e.v2   = alloc_rdy2 ? alloc_v2 : cdb_data;
    new_e.age  = AGE_W'(count_q - CNT_W'(do_iss));
  end

  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].busy && cdb_valid) begin
        if (!entries_q[i].rdy1 && entries_q[i].t1 == cdb_tag) begin
          entries_d[i].rdy1 = 1'b1;
          entries_d[i].v1   = cdb_data;
        end
        if (!entries_q[i].rdy2 && entries_q[i].t2 == cdb_tag) begin
          entries_d[i].rdy2 = 1'b1;
          entries_d[i].v2   = cdb_data;
        end
      end
      if (do_iss && entries_q[i].busy && entries_q[i].age > entries_q[sel_idx].age)
        entries_d[i].age = entries_q[i].age - AGE_W'(1);
    end
    if (do_iss) entries_d[sel_idx].busy = 1'b0;
    if (do_alloc) entries_d[free_idx] = new_e;
    count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_iss);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].busy = 1'b0;
      count_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entry array is a handful of flops, reset in full so no X can leak to iss_*.
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q       <= '0;
      alloc_ready_q <= 1'b1;
    end else begin
      entries_q     <= entries_d;
      count_q       <= count_d;
      alloc_ready_q <= (count_d < CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: an age-ordered queue model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_rs_station;
  import tomasulo_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush, alloc_valid, alloc_ready;
  logic [3:0]  alloc_func, alloc_rd;
  logic [2:0]  alloc_rob, alloc_t1, alloc_t2;
  logic        alloc_rdy1, alloc_rdy2;
  logic [15:0] alloc_v1, alloc_v2;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        iss_valid, iss_ready;
  logic [3:0]  iss_func, iss_rd;
  logic [15:0] iss_v1, iss_v2;
  logic [2:0]  iss_rob;
  logic [2:0]  count;

  rs_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_func(alloc_func), .alloc_rob(alloc_rob), .alloc_rd(alloc_rd),
    .alloc_rdy1(alloc_rdy1), .alloc_v1(alloc_v1), .alloc_t1(alloc_t1),
    .alloc_rdy2(alloc_rdy2), .alloc_v2(alloc_v2), .alloc_t2(alloc_t2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_rob(iss_rob), .iss_rd(iss_rd),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: queue position is age; the front is the oldest instruction.
  rs_entry_t mq[$];

  function automatic int model_pick();
    for (int j = 0; j < mq.size(); j++)
      if (mq[j].rdy1 && mq[j].rdy2) return j;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int j;
    bit room;
    rs_entry_t e;
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      room = mq.size() < DEPTH;
      j = model_pick();
      if (cdb_valid) begin
        for (int k = 0; k < mq.size(); k++) begin
          e = mq[k];
          if (!e.rdy1 && e.t1 == cdb_tag) begin e.rdy1 = 1'b1; e.v1 = cdb_data; end
          if (!e.rdy2 && e.t2 == cdb_tag) begin e.rdy2 = 1'b1; e.v2 = cdb_data; end
          mq[k] = e;
        end
      end
      if (j >= 0 && iss_ready) mq.delete(j);
      if (alloc_valid && room) begin
        e = '0;
        e.func = alloc_func; e.rob = alloc_rob; e.rd = alloc_rd;
        e.t1 = alloc_t1; e.t2 = alloc_t2;
        e.rdy1 = alloc_rdy1 || (cdb_valid && alloc_t1 == cdb_tag);
        e.rdy2 = alloc_rdy2 || (cdb_valid && alloc_t2 == cdb_tag);
        e.v1 = alloc_rdy1 ? alloc_v1 : cdb_data;
        e.v2 = alloc_rdy2 ? alloc_v2 : cdb_data;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    int j;
    logic [63:0] exp_iss;
    j = model_pick();
    exp_iss = '0;
    if (j >= 0 && !flush)
      exp_iss = {20'd0, 1'b1, mq[j].func, mq[j].rob, mq[j].rd, mq[j].v1, mq[j].v2};
    check("iss_bundle", {20'd0, iss_valid, iss_func, iss_rob, iss_rd, iss_v1, iss_v2}, exp_iss);
    check("count", 64'(count), 64'(mq.size()));
    check("alloc_ready", 64'(alloc_ready), 64'(mq.size() < DEPTH));
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_func = '0; alloc_rob = '0; alloc_rd = '0;
    alloc_rdy1 = 0; alloc_v1 = '0; alloc_t1 = '0;
    alloc_rdy2 = 0; alloc_v2 = '0; alloc_t2 = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; flush = 0;
  endtask

  task automatic alloc(input logic [3:0] f, input logic [2:0] rob, input logic [3:0] rd,
                       input logic r1, input logic [15:0] v1, input logic [2:0] t1,
                       input logic r2, input logic [15:0] v2, input logic [2:0] t2);
    alloc_valid = 1; alloc_func = f; alloc_rob = rob; alloc_rd = rd;
    alloc_rdy1 = r1; alloc_v1 = v1; alloc_t1 = t1;
    alloc_rdy2 = r2; alloc_v2 = v2; alloc_t2 = t2;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
    cdb_valid = 1; cdb_tag = tag; cdb_data = data;
  endtask

  initial begin
    idle();
    iss_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_iss_valid", iss_valid, 0);
    adv();
    rst_n = 1;

    // Fill with four ready instructions, then offer a fifth while full.
    for (int k = 1; k <= 4; k++) begin
      alloc(OP_ADD, 3'(k), 4'(k), 1, 16'(k * 10), 3'd0, 1, 16'(k), 3'd0);
      adv();
    end
    alloc(OP_SUB, 3'd5, 4'd5, 1, 16'h0055, 3'd0, 1, 16'h0005, 3'd0);
    @(negedge clk);
    check("fill_count", count, 4);
    check("fill_alloc_ready", alloc_ready, 0);
    check("fill_iss_valid", iss_valid, 1);
    check("fill_iss_rob", iss_rob, 1);
    adv();
    idle();
    @(negedge clk);
    check("full_ignored_count", count, 4);
    check("full_ignored_rob", iss_rob, 1);
    adv();

    // Oldest-first drain.
    iss_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("drain_rob", iss_rob, 64'(k));
      check("drain_v1", iss_v1, 64'(k * 10));
      check("drain_count", count, 64'(5 - k));
      adv();
    end
    @(negedge clk);
    check("drained_valid", iss_valid, 0);
    check("drained_count", count, 0);
    adv();
    iss_ready = 0;

    // Wakeup through the CDB, with no same-cycle CDB-to-issue path.
    alloc(OP_ADD, 3'd1, 4'd2, 0, 16'd0, 3'd5, 1, 16'd7, 3'd0);
    adv();
    idle();
    @(negedge clk);
    check("wait_valid", iss_valid, 0);
    adv();
    cdb(3'd5, 16'd3);
    @(negedge clk);
    check("cdb_no_comb", iss_valid, 0);
    adv();
    idle();
    @(negedge clk);
    check("wake_valid", iss_valid, 1);
    check("wake_v1", iss_v1, 3);
    check("wake_v2", iss_v2, 7);
    iss_ready = 1;
    adv();
    iss_ready = 0;

    // Both operands woken by a single broadcast.
    alloc(OP_MUL, 3'd5, 4'd6, 0, 16'd0, 3'd4, 0, 16'd0, 3'd4);
    adv();
    idle();
    cdb(3'd4, 16'h0011);
    adv();
    idle();
    @(negedge clk);
    check("both_v1", iss_v1, 16'h0011);
    check("both_v2", iss_v2, 16'h0011);
    iss_ready = 1;
    adv();
    iss_ready = 0;

    // Allocation-time bypass.
    alloc(OP_LD, 3'd2, 4'd3, 1, 16'd1, 3'd0, 0, 16'd0, 3'd6);
    cdb(3'd6, 16'h00AA);
    adv();
    idle();
    @(negedge clk);
    check("bypass_valid", iss_valid, 1);
    check("bypass_v2", iss_v2, 16'h00AA);
    iss_ready = 1;
    adv();
    iss_ready = 0;

    // Younger ready entry overtakes an older waiting one.
    alloc(OP_BEQ, 3'd2, 4'd1, 0, 16'd0, 3'd7, 1, 16'd5, 3'd0);
    adv();
    alloc(OP_BNE, 3'd3, 4'd2, 1, 16'd4, 3'd0, 1, 16'd4, 3'd0);
    adv();
    idle();
    iss_ready = 1;
    @(negedge clk);
    check("ooo_first_rob", iss_rob, 3);
    adv();
    @(negedge clk);
    check("ooo_wait_valid", iss_valid, 0);
    cdb(3'd7, 16'd9);
    adv();
    idle();
    @(negedge clk);
    check("ooo_second_rob", iss_rob, 2);
    check("ooo_second_v1", iss_v1, 9);
    adv();
    iss_ready = 0;

    // Simultaneous allocate and dispatch, then flush.
    alloc(OP_ADD, 3'd1, 4'd1, 1, 16'd1, 3'd0, 1, 16'd1, 3'd0);
    adv();
    alloc(OP_SUB, 3'd2, 4'd2, 1, 16'd2, 3'd0, 1, 16'd2, 3'd0);
    adv();
    alloc(OP_MUL, 3'd3, 4'd3, 1, 16'd3, 3'd0, 1, 16'd3, 3'd0);
    iss_ready = 1;
    @(negedge clk);
    check("simul_pre_count", count, 2);
    check("simul_pre_rob", iss_rob, 1);
    adv();
    idle();
    iss_ready = 0;
    @(negedge clk);
    check("simul_post_count", count, 2);
    check("simul_post_rob", iss_rob, 2);
    iss_ready = 1;
    adv();
    iss_ready = 0;
    @(negedge clk);
    check("simul_youngest_rob", iss_rob, 3);
    check("simul_youngest_count", count, 1);
    adv();
    alloc(OP_DIV, 3'd4, 4'd4, 1, 16'd4, 3'd0, 1, 16'd4, 3'd0);
    flush = 1;
    @(negedge clk);
    check("flush_valid", iss_valid, 0);
    adv();
    idle();
    @(negedge clk);
    check("flush_count", count, 0);
    check("flush_alloc_ready", alloc_ready, 1);

    // Asynchronous reset in the middle of traffic.
    adv();
    alloc(OP_ST, 3'd5, 4'd1, 1, 16'd8, 3'd0, 1, 16'd8, 3'd0);
    adv();
    alloc(OP_LD, 3'd6, 4'd2, 1, 16'd9, 3'd0, 1, 16'd9, 3'd0);
    adv();
    idle();
    @(negedge clk);
    check("pre_reset_count", count, 2);
    adv();
    rst_n = 0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_ready", alloc_ready, 1);
    check("async_rst_valid", iss_valid, 0);
    check("async_rst_rob", iss_rob, 0);
    adv();
    rst_n = 1;
    @(negedge clk);
    check("post_rst_valid", iss_valid, 0);
    adv();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Parametrised reservation station for the Tomasulo core. One instance per functional-unit class (add/sub/branch, mul/div, load/store).
- Accepts renamed instructions from the issue stage and captures operand values from the common data bus (CDB) as they are broadcast.
- Each cycle it dispatches the oldest entry whose operands are both ready to its functional unit.
- Replaces hierarchical array writes with a self-contained, handshaked block.

Parameters:
- DEPTH, 4: number of entries; 2..16.
- FUNC_W, 4: opcode width.
- ROB_W, 3: ROB index (tag) width.
- REG_W, 4: architectural destination register width.
- DATA_W, 16: operand width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries (branch mispredict).
- alloc_valid  in  1  issue stage presents an instruction.
- alloc_ready  out  1  station can accept; registered, equals (count < DEPTH).
- alloc_func  in  FUNC_W  opcode.
- alloc_rob  in  ROB_W  ROB index of the instruction.
- alloc_rd  in  REG_W  destination register.
- alloc_rdy1  in  1  1 = alloc_v1 holds the value; 0 = wait on alloc_t1.
- alloc_v1  in  DATA_W  operand-1 value.
- alloc_t1  in  ROB_W  operand-1 producer tag.
- alloc_rdy2, alloc_v2, alloc_t2: same as above, for operand 2.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  ROB_W  ROB index being broadcast.
- cdb_data  in  DATA_W  broadcast result.
- iss_valid  out  1  an entry is dispatched this cycle.
- iss_ready  in  1  functional unit accepts.
- iss_func  out  FUNC_W  opcode of the dispatched entry.
- iss_v1  out  DATA_W  operand-1 value.
- iss_v2  out  DATA_W  operand-2 value.
- iss_rob  out  ROB_W  ROB index.
- iss_rd  out  REG_W  destination register.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Entry fields: busy, func, rob, rd, rdy1, v1, t1, rdy2, v2, t2, age.
- Reset (async, rst_n=0):
  - All busy=0, count=0, alloc_ready=1.
  - iss_valid=0; iss_func/iss_v1/iss_v2/iss_rob/iss_rd all 0.
  - Reset mid-operation discards every entry; no dispatch on the deasserting edge.
- Allocation (alloc_valid & alloc_ready at the edge):
  - Writes the lowest-index free entry and sets busy.
  - age = count before the edge; 0 is the oldest.
- Allocation-time CDB bypass: if rdyN=0, cdb_valid=1 and cdb_tag==tN in the same cycle, the entry is written with rdyN=1 and vN=cdb_data.
- Wakeup: every busy entry with rdyN=0 and tN==cdb_tag on a cdb_valid cycle sets rdyN=1 and vN=cdb_data at the edge. Both operands may wake together.
- Selection (combinational from registered state):
  - Candidate = busy & rdy1 & rdy2.
  - iss_valid = any candidate; the iss_* fields come from the candidate with the smallest age.
  - Outputs are 0 when iss_valid=0.
- Latency:
  - An entry allocated at edge N can first drive iss_valid in cycle N+1.
  - An entry woken by the CDB at edge N can first dispatch in cycle N+1; no CDB-to-issue combinational path.
- Dispatch (iss_valid & iss_ready at the edge):
  - Clears busy on the selected entry.
  - Every busy entry with age greater than the dispatched entry's age decrements its age by 1.
  - If iss_ready=0, the same entry stays selected unless an older entry becomes ready.
- Simultaneous allocate and dispatch:
  - Both take effect; count is unchanged.
  - The new entry's age = count-1.
  - The freed slot is not reused in the same cycle.
  - alloc_ready is computed from pre-edge count only, so a full station rejects allocation even while dispatching.
- Full: count==DEPTH makes alloc_ready=0. An alloc_valid held while full is ignored; no entry is written.
- Empty: iss_valid=0. CDB traffic is ignored.
- flush (synchronous, takes priority over allocate, dispatch and wakeup): all busy=0, count=0. iss_valid is forced to 0 in the flush cycle.
- Tag width: ROB_W must equal the ROB index width. Comparisons are exact equality only.

Decomposition:
- Shared package tomasulo_pkg holds:
  - FUNC_W and ROB_W defaults.
  - Opcode constants: ADD=0000, SUB=0001, MUL=0010, DIV=0011, LD=0100, ST=0101, BEQ=0110, BNE=0111.
  - The rs_entry_t struct typedef.
- One sub-module, rs_age_select: a combinational oldest-ready picker over DEPTH entries. Returns the selected index and a found flag.

Test Plan:
1. Reset then fill: DEPTH=4; allocate 4 entries, all operands ready (rob 1..4); hold iss_ready=0 -> count=4 and alloc_ready=0 on the next cycle; a 5th alloc_valid is ignored; iss_rob=1.
2. Oldest-first drain: from scenario 1, set iss_ready=1 -> iss_rob sequence 1,2,3,4 on consecutive cycles; count goes 3,2,1,0; iss_valid=0 afterward.
3. CDB wakeup: allocate ADD with rdy1=0, t1=5, v2=7 -> iss_valid=0. Then broadcast cdb_tag=5, cdb_data=3 -> next cycle iss_valid=1, iss_v1=3, iss_v2=7.
4. Allocation bypass: alloc with rdy2=0, t2=6 in the same cycle as cdb_valid, tag 6, data 0x00AA -> next cycle iss_v2=0x00AA, iss_valid=1.
5. Out-of-order readiness: entry A (rob 2) waits on tag 7; entry B (rob 3) is ready -> B dispatches first. Broadcast tag 7 -> A dispatches next.
6. Simultaneous allocate+dispatch and flush: with count=2, allocate and dispatch in one cycle -> count stays 2 and the new entry becomes youngest. Then assert flush with alloc_valid=1 -> count=0, iss_valid=0; the allocation is dropped. rst_n pulsed mid-stream -> all outputs return to reset values immediately.
